// File: rtl/ed_pkg.sv
// Shared types and helpers for the edge-detection front end.
// Holds the sequencer state encoding and line-buffer rotation math.
package ed_pkg;

    localparam int PIX_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        LAST = 2'd3
    } state_t;

    // Rotate a line-buffer index forward by off positions, modulo 3.
    function automatic logic [1:0] buf_idx(
        input logic [1:0] sel,
        input logic [1:0] off
    );
        logic [2:0] s;
        s = {1'b0, sel} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/ed_line_buffer.sv
// One image row of pixel storage for the Gaussian sequencer.
// Synchronous write port, combinational read port.
module ed_line_buffer #(
    parameter int IMG_W = 320,
    parameter int PIX_W = 12,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Store the incoming pixel at its column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ed_gaussian_sequencer.sv
// Raster-to-column sequencer feeding the 3x3 Gaussian kernel.
// Rows rotate through three line buffers; outputs are registered.
module ed_gaussian_sequencer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = ed_pkg::PIX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pix_valid,
    input  logic [PIX_W-1:0]           pix_in,
    output logic                       pix_ready,
    output logic [PIX_W-1:0]           top_line_out,
    output logic [PIX_W-1:0]           mid_line_out,
    output logic [PIX_W-1:0]           bot_line_out,
    output logic                       at_left,
    output logic                       at_right,
    output logic                       at_top,
    output logic                       at_bottom,
    output logic                       win_valid,
    output logic [$clog2(IMG_W)-1:0]   center_x,
    output logic [$clog2(IMG_H)-1:0]   center_y,
    output logic                       busy,
    output logic                       frame_done
);
    import ed_pkg::*;

    localparam int XW  = $clog2(IMG_W + 1);
    localparam int RW  = $clog2(IMG_H + 1);
    localparam int AW  = $clog2(IMG_W);
    localparam int CXW = $clog2(IMG_W);
    localparam int CYW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_END = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_PAD = XW'(IMG_W);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_H);

    state_t         st, st_nxt;
    logic [XW-1:0]  wr_x, wr_x_nxt;
    logic [XW-1:0]  bcnt, bcnt_nxt;
    logic [1:0]     wr_sel, wr_sel_nxt;
    logic [RW-1:0]  row_cnt, row_cnt_nxt;
    logic           done_nxt;
    logic           accept;

    logic [2:0]       we;
    logic [AW-1:0]    rd_col;
    logic [PIX_W-1:0] rd_data [3];

    logic             emit_n, data_n;
    logic [1:0]       t_i, m_i, b_i;
    logic [PIX_W-1:0] top_n, mid_n, bot_n;
    logic             al_n, ar_n, at_n, ab_n, wv_n;
    logic [CXW-1:0]   cx_n;
    logic [CYW-1:0]   cy_n;

    function automatic logic [PIX_W-1:0] pick(
        input logic [1:0]       i,
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        return (i == 2'd0) ? a : (i == 2'd1) ? b : c;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_buf
        ed_line_buffer #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W),
            .AW    (AW)
        ) u_buf (
            .clk     (clk),
            .we      (we[g]),
            .wr_addr (wr_x[AW-1:0]),
            .wr_data (pix_in),
            .rd_addr (rd_col),
            .rd_data (rd_data[g])
        );
    end

    assign accept = (st == LOAD) && pix_valid;

    // Next-state, counters and buffer write enables.
    always_comb begin
        st_nxt      = st;
        wr_x_nxt    = wr_x;
        bcnt_nxt    = bcnt;
        wr_sel_nxt  = wr_sel;
        row_cnt_nxt = row_cnt;
        done_nxt    = 1'b0;
        we          = '0;
        for (int i = 0; i < 3; i++) begin
            we[i] = accept && (wr_sel == 2'(i));
        end
        unique case (st)
            IDLE: begin
                if (start) begin
                    st_nxt      = LOAD;
                    wr_x_nxt    = '0;
                    wr_sel_nxt  = 2'd0;
                    row_cnt_nxt = '0;
                end
            end
            LOAD: begin
                if (pix_valid) begin
                    if (wr_x == X_END) begin
                        wr_x_nxt    = '0;
                        wr_sel_nxt  = buf_idx(wr_sel, 2'd1);
                        row_cnt_nxt = row_cnt + RW'(1);
                        if (row_cnt != '0) begin
                            st_nxt   = EMIT;
                            bcnt_nxt = '0;
                        end
                    end else begin
                        wr_x_nxt = wr_x + XW'(1);
                    end
                end
            end
            EMIT: begin
                if (bcnt == X_PAD) begin
                    bcnt_nxt = '0;
                    st_nxt   = (row_cnt < R_MAX) ? LOAD : LAST;
                end else begin
                    bcnt_nxt = bcnt + XW'(1);
                end
            end
            LAST: begin
                if (bcnt == X_PAD) begin
                    bcnt_nxt = '0;
                    st_nxt   = IDLE;
                    done_nxt = 1'b1;
                end else begin
                    bcnt_nxt = bcnt + XW'(1);
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Beat contents for the cycle being entered, so outputs stay registered.
    always_comb begin
        emit_n = (st_nxt == EMIT) || (st_nxt == LAST);
        data_n = emit_n && (bcnt_nxt != X_PAD);
        rd_col = data_n ? bcnt_nxt[AW-1:0] : '0;
        if (st_nxt == LAST) begin
            t_i = buf_idx(wr_sel_nxt, 2'd1);
            m_i = buf_idx(wr_sel_nxt, 2'd2);
            b_i = wr_sel_nxt;
        end else begin
            t_i = wr_sel_nxt;
            m_i = buf_idx(wr_sel_nxt, 2'd1);
            b_i = buf_idx(wr_sel_nxt, 2'd2);
        end
        at_n  = (st_nxt == EMIT) && (row_cnt_nxt == RW'(2));
        ab_n  = (st_nxt == LAST);
        al_n  = emit_n && (bcnt_nxt == XW'(1));
        ar_n  = emit_n && (bcnt_nxt == X_PAD);
        wv_n  = emit_n && (bcnt_nxt != '0);
        top_n = '0;
        mid_n = '0;
        bot_n = '0;
        if (data_n) begin
            mid_n = pick(m_i, rd_data[0], rd_data[1], rd_data[2]);
            if (!at_n) begin
                top_n = pick(t_i, rd_data[0], rd_data[1], rd_data[2]);
            end
            if (!ab_n) begin
                bot_n = pick(b_i, rd_data[0], rd_data[1], rd_data[2]);
            end
        end
        cx_n = '0;
        cy_n = '0;
        if (wv_n) begin
            cx_n = CXW'(bcnt_nxt - XW'(1));
            cy_n = ab_n ? CYW'(IMG_H - 1) : CYW'(row_cnt_nxt - RW'(2));
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            wr_x         <= '0;
            bcnt         <= '0;
            wr_sel       <= 2'd0;
            row_cnt      <= '0;
            pix_ready    <= 1'b0;
            top_line_out <= '0;
            mid_line_out <= '0;
            bot_line_out <= '0;
            at_left      <= 1'b0;
            at_right     <= 1'b0;
            at_top       <= 1'b0;
            at_bottom    <= 1'b0;
            win_valid    <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            st           <= st_nxt;
            wr_x         <= wr_x_nxt;
            bcnt         <= bcnt_nxt;
            wr_sel       <= wr_sel_nxt;
            row_cnt      <= row_cnt_nxt;
            pix_ready    <= (st_nxt == LOAD);
            top_line_out <= top_n;
            mid_line_out <= mid_n;
            bot_line_out <= bot_n;
            at_left      <= al_n;
            at_right     <= ar_n;
            at_top       <= at_n;
            at_bottom    <= ab_n;
            win_valid    <= wv_n;
            center_x     <= cx_n;
            center_y     <= cy_n;
            busy         <= (st_nxt != IDLE);
            frame_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ed_gaussian_sequencer.sv
// Scoreboard bench for ed_gaussian_sequencer with a small frame.
// Expected beats come from a row-array model of the kernel window.
module tb_ed_gaussian_sequencer;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int PW  = 12;
    localparam int CXW = $clog2(W);
    localparam int CYW = $clog2(H);
    localparam int FRAME_LEN = H * W + H * (W + 1) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           pix_valid = 1'b0;
    logic [PW-1:0]  pix_in = '0;
    logic           pix_ready;
    logic [PW-1:0]  top_line_out, mid_line_out, bot_line_out;
    logic           at_left, at_right, at_top, at_bottom;
    logic           win_valid;
    logic [CXW-1:0] center_x;
    logic [CYW-1:0] center_y;
    logic           busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [PW-1:0] img [H][W];
    logic [63:0]   sb [$];

    ed_gaussian_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_in       (pix_in),
        .pix_ready    (pix_ready),
        .top_line_out (top_line_out),
        .mid_line_out (mid_line_out),
        .bot_line_out (bot_line_out),
        .at_left      (at_left),
        .at_right     (at_right),
        .at_top       (at_top),
        .at_bottom    (at_bottom),
        .win_valid    (win_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [63:0] exp_beat(input int c, input int j);
        logic [PW-1:0]  t, m, b;
        logic           wv;
        logic [CXW-1:0] cx;
        logic [CYW-1:0] cy;
        t = '0;
        m = '0;
        b = '0;
        if (j < W) begin
            m = img[c][j];
            if (c > 0) t = img[c-1][j];
            if (c < H - 1) b = img[c+1][j];
        end
        wv = (j >= 1);
        cx = wv ? CXW'(j - 1) : '0;
        cy = wv ? CYW'(c) : '0;
        return 64'({t, m, b, j == 1, j == W, c == 0, c == H - 1,
                    wv, cx, cy});
    endfunction

    function automatic logic [63:0] act_beat();
        return 64'({top_line_out, mid_line_out, bot_line_out,
                    at_left, at_right, at_top, at_bottom, win_valid,
                    win_valid ? center_x : CXW'(0),
                    win_valid ? center_y : CYW'(0)});
    endfunction

    function automatic logic [63:0] idle_vec();
        return 64'({top_line_out, mid_line_out, bot_line_out,
                    at_left, at_right, at_top, at_bottom, win_valid,
                    center_x, center_y});
    endfunction

    task automatic push_centre(input int c);
        for (int j = 0; j <= W; j++) begin
            sb.push_back(exp_beat(c, j));
        end
    endtask

    // Monitor: a beat is any cycle that is busy with the input stalled.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !pix_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got %0h expected none",
                             act_beat());
                end else begin
                    chk("beat", act_beat(), sb.pop_front());
                end
            end else begin
                chk("idle_zero", idle_vec(), 64'd0);
            end
        end
    end

    task automatic feed_row(input int r, input bit gaps, input bit hold);
        int  x;
        int  g;
        bit  v;
        bit  rdy;
        x = 0;
        g = 0;
        while (x < W && g < 200) begin
            rdy = pix_ready;
            v = gaps ? bit'($urandom % 2) : 1'b1;
            if (hold) v = 1'b1;
            pix_valid = v;
            pix_in = (v && rdy) ? img[r][x] : PW'($urandom);
            step();
            g++;
            if (v && rdy) x++;
            if (x > 0 && x < W) chk("ready_hold", 64'(pix_ready), 64'd1);
        end
        chk("feed_timeout", 64'(x), 64'(W));
    endtask

    task automatic run_frame(input int mode, input bit abort);
        bit gaps;
        bit hold;
        int c0;
        int n;
        gaps = (mode == 1);
        hold = (mode == 2);
        for (int r = 0; r < H; r++) begin
            for (int x = 0; x < W; x++) begin
                img[r][x] = (mode == 0) ? PW'(r * W + x + 1) : PW'($urandom);
            end
        end
        start = 1'b1;
        c0 = cyc;
        step();
        start = hold;
        for (int r = 0; r < H; r++) begin
            feed_row(r, gaps, hold);
            if (r == 0) begin
                chk("ready_after_row0", 64'(pix_ready), 64'd1);
                continue;
            end
            push_centre(r - 1);
            if (r == H - 1) push_centre(H - 1);
            chk("emit_start", 64'({busy, pix_ready}), 64'b10);
            if (abort) begin
                step();
                step();
                reset = 1'b1;
                step();
                chk("reset_flags", 64'({busy, pix_ready, frame_done}), 64'd0);
                chk("reset_outs", idle_vec(), 64'd0);
                reset = 1'b0;
                pix_valid = 1'b0;
                start = 1'b0;
                sb.delete();
                return;
            end
            if (r == H - 1) start = 1'b0;
            n = 0;
            while (busy && !pix_ready && n < 50) begin
                pix_valid = hold ? 1'b1 : bit'($urandom % 2);
                pix_in = PW'($urandom);
                step();
                n++;
            end
            chk("burst_len", 64'(n), (r == H - 1) ? 64'(2 * (W + 1))
                                                   : 64'(W + 1));
        end
        chk("frame_done", 64'({frame_done, busy}), 64'b10);
        if (!gaps) chk("frame_len", 64'(cyc - c0), 64'(FRAME_LEN));
        pix_valid = 1'b0;
        step();
        chk("done_pulse", 64'(frame_done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_state", 64'({busy, pix_ready, frame_done}), 64'd0);
        chk("reset_outs0", idle_vec(), 64'd0);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b1);
        run_frame(1, 1'b0);
        run_frame(0, 1'b0);
        repeat (3) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ed_gaussian_sequencer.md
# ed_gaussian_sequencer

Frame sequencer that feeds the edge-detection Gaussian smoothing kernel. It accepts a raster pixel stream and stores rows in three rotating line buffers. For each image row it then emits a contiguous burst of 3-row columns (top/mid/bot) with at_left/at_right/at_top/at_bottom flags aligned to the kernel's 3-column shift window. It sits between the camera/frame source and the kernel, and also supplies centre coordinates and a valid strobe to downstream edge stages.

## Interface
- IMG_W, 320, pixels per row (≥2)
- IMG_H, 240, rows per frame (≥2)
- PIX_W, 12, pixel width (RGB444)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin frame; honoured only in IDLE
- pix_valid  in  1  pix_in valid; ignored while pix_ready=0
- pix_in  in  PIX_W  raster pixel
- pix_ready  out  1  high only in LOAD
- top_line_out, mid_line_out, bot_line_out  out  PIX_W each  column to kernel
- at_left, at_right, at_top, at_bottom  out  1 each  kernel edge flags
- win_valid  out  1  current beat completes a valid centre
- center_x  out  clog2(IMG_W)  centre column of the valid beat
- center_y  out  clog2(IMG_H)  centre row of the valid beat
- busy  out  1  not IDLE
- frame_done  out  1  one-cycle pulse at frame end

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, LOAD, EMIT, LAST.
- IDLE → LOAD on start.
- LOAD: each accepted pixel is written to buffer wr_sel at column wr_x. When the IMG_W-th pixel is accepted, wr_sel advances mod 3 and row_cnt increments.
  - After row 0: stay in LOAD.
  - After row r≥1: go to EMIT for centre r−1.
- EMIT: IMG_W+1 back-to-back beats j=0..IMG_W.
  - Beats j<IMG_W present column j: top = buffer(wr_sel−3), mid = (wr_sel−2), bot = (wr_sel−1), all mod 3.
  - Beat j=IMG_W is a pad beat with all lines 0.
  - After the last beat: if row_cnt<IMG_H go to LOAD, else go to LAST.
- LAST: same IMG_W+1 beats for centre IMG_H−1. top = row IMG_H−2, mid = row IMG_H−1, bot forced 0. Then IDLE with frame_done.
- Flags during beat j:
  - at_left = (j==1)
  - at_right = (j==IMG_W)
  - at_top = 1 for the whole burst of centre 0; top line forced 0
  - at_bottom = 1 for the whole LAST burst
- win_valid = 1 for j=1..IMG_W, with center_x=j−1 and center_y=current centre row.
- Outside EMIT/LAST, all data outputs, flags and win_valid are 0.
- Edge cases:
  - pix_valid while pix_ready=0: no effect.
  - start outside IDLE: no effect.
  - Reset mid-frame: IDLE next cycle, all outputs 0, buffer contents don't-care.
- Counters: wr_x and beat counter are clog2(IMG_W+1) bits; row_cnt is clog2(IMG_H+1) bits. No wrap within a frame.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Beat j is visible in cycle E+j, where E is the first cycle in EMIT/LAST.
- EMIT/LAST start the cycle after the last pixel of a row is accepted. pix_ready is 0 from that cycle.
- pix_ready returns to 1 the cycle after the pad beat.
- Kernel adds one cycle: smoothed pixel for (center_x, center_y) appears one cycle after the win_valid beat.
- frame_done pulses in the first IDLE cycle; start is accepted in that same cycle. busy is 0 then.
- With continuous input, frame length = IMG_H·IMG_W + IMG_H·(IMG_W+1) + 1 cycles from start.

## Structure
- Package ed_pkg holds:
  - the state enum
  - PIX_W
  - mod-3 buffer index helper
- Sub-module ed_line_buffer: IMG_W×PIX_W register array with one synchronous write port and one combinational read port. Instantiated 3×; the three read ports are muxed by wr_sel.

## Test plan
- IMG_W=4, IMG_H=3, pixels 0x001..0x00C, continuous → three 5-beat bursts.
  - Centre 0 burst: mid 0x001..0x004, bot 0x005..0x008, at_top=1.
  - Pad beat lines are 0.
  - at_left on beat 1, at_right on beat 4.
  - frame_done after the LAST burst.
- IMG_W=4, IMG_H=2 → two bursts: first with at_top, second with at_bottom. No LOAD between them.
- pix_valid toggling every other cycle during LOAD → pix_ready stays 1. EMIT starts exactly one cycle after the 4th accepted pixel.
- pix_valid and start held high throughout → extra pixels during EMIT are dropped, buffers are unaffected, and a second start mid-frame is ignored.
- Reset asserted on EMIT beat 2 → next cycle busy=0 and all outputs 0. A new start then produces a clean frame.
- Paired with the kernel, a constant 0x888 frame with IMG_W=IMG_H=4 produces:
  - interior outputs 0x888
  - non-corner edge outputs 0x666
  - corner outputs 0x444
